// File: rtl/btn_cmd_conditioner.sv
// btn_cmd_conditioner
// Turns the raw board push-button and mode switch into clean, one-shot
// commands for the demo sequencer. Both raw inputs are synchronised and
// debounced. A one-deep pending slot holds a press that arrives while the
// sequencer is busy, and presses that find the slot full are counted.
// A button held through reset is ignored until it has been seen released.
//
// Optional feature: define BTN_AUTO_REPEAT_EN to generate repeat presses
// while the button is held (first after REPEAT_DELAY, then every
// REPEAT_PERIOD cycles). Without it a held button yields one press only.

module btn_cmd_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_WIDTH       = 25,
   parameter int HOLDOFF         = 2,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start_btn_n,
   input  logic       mode_sw,
   input  logic       ready,
   output logic       start_n_out,
   output logic       mode_out,
   output logic       cmd_pulse,
   output logic       pending,
   output logic [7:0] drop_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam int                   HO_W     = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [HO_W-1:0]      HO_LOAD  = HO_W'(HOLDOFF);
   localparam logic [HO_W-1:0]      HO_ZERO  = HO_W'(0);
   localparam logic [HO_W-1:0]      HO_ONE   = HO_W'(1);

   typedef enum logic [0:0] {
      BTN_UP   = 1'b0,
      BTN_DOWN = 1'b1
   } btn_state_t;

   // Saturating increment for the 8-bit drop counter
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      if (val == 8'hFF) begin
         sat_inc8 = 8'hFF;
      end else begin
         sat_inc8 = val + 8'd1;
      end
   endfunction

   logic                 start_meta_r;
   logic                 start_sync_r;
   logic                 mode_meta_r;
   logic                 mode_sync_r;
   logic [1:0]           sync_vld_r;
   logic                 start_stable_r;
   logic                 mode_stable_r;
   logic [CNT_WIDTH-1:0] start_cnt_r;
   logic [CNT_WIDTH-1:0] mode_cnt_r;
   logic                 armed_r;
   logic [CNT_WIDTH-1:0] arm_cnt_r;
   btn_state_t           state_r;
   logic [HO_W-1:0]      holdoff_r;
   logic                 pending_r;
   logic [7:0]           drop_cnt_r;
   logic                 start_n_out_r;
   logic                 mode_out_r;
   logic                 cmd_pulse_r;
   logic                 btn_press_s;
   logic                 rpt_press_s;
   logic                 press_s;
   logic                 issue_s;

   // Two-flop synchronisers; sync_vld_r marks when start_sync_r holds a real sample
   always_ff @(posedge clk) begin
      if (!rstn) begin
         start_meta_r <= 1'b1;
         start_sync_r <= 1'b1;
         mode_meta_r  <= 1'b0;
         mode_sync_r  <= 1'b0;
         sync_vld_r   <= 2'b00;
      end else begin
         start_meta_r <= start_btn_n;
         start_sync_r <= start_meta_r;
         mode_meta_r  <= mode_sw;
         mode_sync_r  <= mode_meta_r;
         sync_vld_r   <= {sync_vld_r[0], 1'b1};
      end
   end

   // Debounce the start button: commit a new level after DEBOUNCE_CYCLES differing cycles
   always_ff @(posedge clk) begin
      if (!rstn) begin
         start_stable_r <= 1'b1;
         start_cnt_r    <= CNT_ZERO;
      end else if (start_sync_r == start_stable_r) begin
         start_cnt_r <= CNT_ZERO;
      end else if (start_cnt_r == DB_LAST) begin
         start_stable_r <= start_sync_r;
         start_cnt_r    <= CNT_ZERO;
      end else begin
         start_cnt_r <= start_cnt_r + CNT_ONE;
      end
   end

   // Debounce the mode switch with the same rule as the button
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mode_stable_r <= 1'b0;
         mode_cnt_r    <= CNT_ZERO;
      end else if (mode_sync_r == mode_stable_r) begin
         mode_cnt_r <= CNT_ZERO;
      end else if (mode_cnt_r == DB_LAST) begin
         mode_stable_r <= mode_sync_r;
         mode_cnt_r    <= CNT_ZERO;
      end else begin
         mode_cnt_r <= mode_cnt_r + CNT_ONE;
      end
   end

   // Arm presses only after the button has been seen released for a full debounce window
   always_ff @(posedge clk) begin
      if (!rstn) begin
         armed_r   <= 1'b0;
         arm_cnt_r <= CNT_ZERO;
      end else if (armed_r) begin
         armed_r   <= 1'b1;
         arm_cnt_r <= CNT_ZERO;
      end else if (sync_vld_r[1] && start_sync_r) begin
         if (arm_cnt_r == DB_LAST) begin
            armed_r   <= 1'b1;
            arm_cnt_r <= CNT_ZERO;
         end else begin
            armed_r   <= 1'b0;
            arm_cnt_r <= arm_cnt_r + CNT_ONE;
         end
      end else begin
         armed_r   <= 1'b0;
         arm_cnt_r <= CNT_ZERO;
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_WIDTH-1:0] RPT_FIRST = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] RPT_NEXT  = CNT_WIDTH'(REPEAT_PERIOD - 1);

   logic [CNT_WIDTH-1:0] rpt_cnt_r;
   logic                 rpt_phase_r;
   logic [CNT_WIDTH-1:0] rpt_target_s;

   // Repeat press when the held-time counter reaches the current interval
   always_comb begin
      rpt_target_s = RPT_FIRST;
      rpt_press_s  = 1'b0;
      if (rpt_phase_r) begin
         rpt_target_s = RPT_NEXT;
      end else begin
         rpt_target_s = RPT_FIRST;
      end
      if (armed_r && (state_r == BTN_DOWN) && !start_stable_r && (rpt_cnt_r == rpt_target_s)) begin
         rpt_press_s = 1'b1;
      end else begin
         rpt_press_s = 1'b0;
      end
   end

   // Held-time counter: runs only in DOWN, restarts after each repeat
   always_ff @(posedge clk) begin
      if (!rstn || (state_r != BTN_DOWN)) begin
         rpt_cnt_r   <= CNT_ZERO;
         rpt_phase_r <= 1'b0;
      end else if (rpt_press_s) begin
         rpt_cnt_r   <= CNT_ZERO;
         rpt_phase_r <= 1'b1;
      end else begin
         rpt_cnt_r   <= rpt_cnt_r + CNT_ONE;
         rpt_phase_r <= rpt_phase_r;
      end
   end
`else
   logic unused_rpt_cfg_s;
   assign unused_rpt_cfg_s = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
   assign rpt_press_s      = 1'b0;
`endif

   // Press detection and issue decision for this cycle
   always_comb begin
      btn_press_s = 1'b0;
      press_s     = 1'b0;
      issue_s     = 1'b0;
      if (armed_r && (state_r == BTN_UP) && !start_stable_r) begin
         btn_press_s = 1'b1;
      end else begin
         btn_press_s = 1'b0;
      end
      press_s = btn_press_s | rpt_press_s;
      if ((press_s || pending_r) && ready && (holdoff_r == HO_ZERO)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Button FSM with the pending slot, holdoff, drop counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r       <= BTN_UP;
         holdoff_r     <= HO_ZERO;
         pending_r     <= 1'b0;
         drop_cnt_r    <= 8'd0;
         start_n_out_r <= 1'b1;
         cmd_pulse_r   <= 1'b0;
         mode_out_r    <= 1'b0;
      end else begin
         case (state_r)
            BTN_UP: begin
               if (!start_stable_r) begin
                  state_r <= BTN_DOWN;
               end else begin
                  state_r <= BTN_UP;
               end
            end
            BTN_DOWN: begin
               if (start_stable_r) begin
                  state_r <= BTN_UP;
               end else begin
                  state_r <= BTN_DOWN;
               end
            end
            default: state_r <= BTN_UP;
         endcase

         cmd_pulse_r   <= issue_s;
         start_n_out_r <= ~issue_s;

         if (issue_s) begin
            // A new press arriving while the pending one issues stays in the slot
            mode_out_r <= mode_stable_r;
            pending_r  <= press_s & pending_r;
            holdoff_r  <= HO_LOAD;
         end else begin
            mode_out_r <= mode_out_r;
            if (holdoff_r != HO_ZERO) begin
               holdoff_r <= holdoff_r - HO_ONE;
            end else begin
               holdoff_r <= holdoff_r;
            end
            if (press_s && !pending_r) begin
               pending_r <= 1'b1;
            end else if (press_s) begin
               pending_r  <= 1'b1;
               drop_cnt_r <= sat_inc8(drop_cnt_r);
            end else begin
               pending_r <= pending_r;
            end
         end
      end
   end

   assign start_n_out = start_n_out_r;
   assign mode_out    = mode_out_r;
   assign cmd_pulse   = cmd_pulse_r;
   assign pending     = pending_r;
   assign drop_cnt    = drop_cnt_r;

endmodule
